mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles dm_req may stay high awaiting dm_ack.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 ex_valid  input  1  execute-stage result valid this cycle.
REQ-005 ex_aluop  input  6  execute ALU opcode (LW=6'b010011, SW=6'b010100, LB=6'b010101, SB=6'b010111, LBU=6'b011000; others non-memory).
REQ-006 ex_alu_out  input  32  ALU result or effective address.
REQ-007 ex_rb  input  32  store data (bypassed rB).
REQ-008 ex_rwe  input  1  instruction writes a register.
REQ-009 ex_rd  input  5  destination register.
REQ-010 stall  output  1  upstream must hold its outputs; ex_* are ignored while high.
REQ-011 dm_req, dm_we  output  1 each  memory request and write enable.
REQ-012 dm_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 dm_wdata  output  32; dm_be  output  4  write data and byte enables.
REQ-014 dm_ack  input  1; dm_rdata  input  32  completion and read word (valid with dm_ack).
REQ-015 wb_valid, wb_rwe  output  1 each; wb_rd  output  5; wb_data  output  32  writeback stage register.
REQ-016 mx_bypass  output  32; mx_rd  output  5; do_mx_bypass  output  1  forwarding from wb register to execute.
REQ-017 fault  output  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-019 IDLE, ex_valid, non-memory op: next cycle wb_valid=1, wb_data=ex_alu_out, wb_rd/wb_rwe copied; stall stays 0.
REQ-020 IDLE, ex_valid, memory op, aligned: latch op/address/data/rd, go ACCESS; stall=1 from the following cycle until the RESP cycle inclusive; wb_valid=0 meanwhile.
REQ-021 Alignment: LW/SW need addr[1:0]=00; byte ops always aligned.
REQ-022 Misaligned LW/SW: no dm_req; next cycle wb_valid=1, wb_rwe=0, fault=1; stay IDLE.
REQ-023 ACCESS: dm_req=1, dm_addr/dm_we/dm_be/dm_wdata stable until dm_ack sampled high.
REQ-024 Byte lanes big-endian: addr[1:0]=00 -> bits 31:24 / be 4'b1000; 01 -> 23:16 / 0100; 10 -> 15:8 / 0010; 11 -> 7:0 / 0001.
REQ-025 SW: dm_be=4'b1111, dm_wdata=ex_rb; SB: dm_wdata=ex_rb[7:0] replicated to all four lanes; loads: dm_we=0, dm_be=4'b1111.
REQ-026 dm_ack in ACCESS: capture dm_rdata, go RESP, dm_req low next cycle.
REQ-027 RESP (one cycle): wb_valid=1; LW wb_data=dm_rdata; LB sign-extends selected byte; LBU zero-extends; stores wb_rwe=0; stall=0; next state IDLE.
REQ-028 Minimum memory-op latency ex_valid->wb_valid: 3 cycles with dm_ack in first ACCESS cycle.
REQ-029 Timeout counter counts ACCESS cycles; at TIMEOUT cycles without ack: drop dm_req, fault=1, wb_valid=1, wb_rwe=0, go IDLE.
REQ-030 dm_ack outside ACCESS is ignored.
REQ-031 mx_bypass=wb_data, mx_rd=wb_rd, do_mx_bypass=wb_valid&wb_rwe&(wb_rd!=0).
REQ-032 wb_valid is a one-cycle pulse per accepted instruction; ex_valid=0 in IDLE gives wb_valid=0 next cycle.

Reset
REQ-033 reset_n low at an edge: state IDLE, timeout counter 0, stall/dm_req/dm_we/wb_valid/wb_rwe/do_mx_bypass/fault 0, dm_be 4'b0000, all data/address outputs 0.
REQ-034 Reset mid-ACCESS drops dm_req in the same edge; a later dm_ack is ignored.

Verification
REQ-035 ADD result 32'h0000_0005, rd=3, rwe=1 -> next cycle wb_valid=1, wb_data=5, do_mx_bypass=1, mx_rd=3, stall=0.
REQ-036 LB addr 32'h0000_1001, dm_rdata 32'h1280_3456 acked after 2 ACCESS cycles -> dm_addr 32'h0000_1000, wb_data 32'hFFFF_FF80; LBU same -> 32'h0000_0080.
REQ-037 SB addr 32'h0000_2003, ex_rb 32'h0000_00AB -> dm_we=1, dm_be=4'b0001, dm_wdata 32'hABAB_ABAB, wb_rwe=0.
REQ-038 LW addr 32'h0000_0002 -> no dm_req, fault pulse, wb_valid=1, wb_rwe=0.
REQ-039 LW with dm_ack never asserted -> dm_req high exactly 16 cycles, then fault pulse, stall released, state IDLE.
REQ-040 reset_n low during ACCESS, then dm_ack -> all outputs zero, no wb_valid.

Source files
------------

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if -- data-memory request/response bus between the memory stage
// (master) and the data memory (slave).
//
//   dm_req    master->slave  request held high until dm_ack is sampled
//   dm_we     master->slave  1 = write, 0 = read
//   dm_addr   master->slave  word-aligned byte address
//   dm_wdata  master->slave  write word (byte stores replicate the byte)
//   dm_be     master->slave  byte enables, bit 3 = bits 31:24 (big-endian)
//   dm_ack    slave->master  completion strobe
//   dm_rdata  slave->master  read word, valid together with dm_ack
// -----------------------------------------------------------------------------
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline memory stage.
//
// Accepts one execute-stage result per cycle while idle. Non-memory results go
// straight into the writeback register. Loads and stores are issued on the
// data-memory bus, the upstream pipeline is stalled until the response has
// been formatted, and the result lands in the writeback register. Misaligned
// word accesses and bus timeouts retire as non-writing instructions with a
// one-cycle fault pulse.
//
// Ports
//   clock, reset_n          single clock, synchronous active-low reset
//   ex_valid                execute result valid (ignored while stall is high)
//   ex_aluop[5:0]           opcode; LW/SW/LB/SB/LBU are memory ops
//   ex_alu_out[31:0]        ALU result or effective byte address
//   ex_rb[31:0]             store data
//   ex_rwe, ex_rd[4:0]      register write enable / destination
//   stall                   upstream must hold its outputs
//   dm (master modport)     data-memory bus, see mem_stage_if
//   wb_valid, wb_rwe,
//   wb_rd[4:0], wb_data     writeback stage register
//   mx_bypass, mx_rd,
//   do_mx_bypass            forwarding path from writeback to execute
//   fault                   one-cycle pulse: misaligned access or timeout
//
// Parameter
//   TIMEOUT                 max ACCESS cycles awaiting dm_ack before giving up
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              ex_valid,
  input  logic [5:0]        ex_aluop,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_rb,
  input  logic              ex_rwe,
  input  logic [4:0]        ex_rd,
  output logic              stall,

  mem_stage_if.master       dm,

  output logic              wb_valid,
  output logic              wb_rwe,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,

  output logic [31:0]       mx_bypass,
  output logic [4:0]        mx_rd,
  output logic              do_mx_bypass,

  output logic              fault
);

  // ---------------------------------------------------------------------------
  // Opcodes and FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [5:0] OP_LW  = 6'b010011;
  localparam logic [5:0] OP_SW  = 6'b010100;
  localparam logic [5:0] OP_LB  = 6'b010101;
  localparam logic [5:0] OP_SB  = 6'b010111;
  localparam logic [5:0] OP_LBU = 6'b011000;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;        // ACCESS cycles spent without an ack

  // Latched instruction for the duration of a memory access
  logic [5:0]       r_op;
  logic [1:0]       r_lane;       // byte offset within the word
  logic [4:0]       r_rd;
  logic             r_rwe;
  logic [31:0]      r_rdata;      // word captured with dm_ack

  // Memory bus drivers
  logic             r_dm_req;
  logic             r_dm_we;
  logic [31:0]      r_dm_addr;
  logic [31:0]      r_dm_wdata;
  logic [3:0]       r_dm_be;

  // Writeback register
  logic             r_wb_valid;
  logic             r_wb_rwe;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_fault;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic        w_is_word;
  logic        w_is_byte;
  logic        w_is_mem;
  logic        w_is_store;
  logic        w_misaligned;
  logic [3:0]  w_req_be;
  logic [31:0] w_req_wdata;

  assign w_is_word    = (ex_aluop == OP_LW) || (ex_aluop == OP_SW);
  assign w_is_byte    = (ex_aluop == OP_LB) || (ex_aluop == OP_SB) ||
                        (ex_aluop == OP_LBU);
  assign w_is_mem     = w_is_word || w_is_byte;
  assign w_is_store   = (ex_aluop == OP_SW) || (ex_aluop == OP_SB);
  // Byte accesses can never be misaligned; only word ops check the low bits.
  assign w_misaligned = w_is_word && (ex_alu_out[1:0] != 2'b00);

  // Byte enables and write data for the request about to be issued.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_req_be    = 4'b1111;
    w_req_wdata = 32'h0000_0000;
    if (ex_aluop == OP_SW) begin
      w_req_wdata = ex_rb;
    end else if (ex_aluop == OP_SB) begin
      // Byte is replicated on every lane; the enable picks the one that lands.
      w_req_wdata = {4{ex_rb[7:0]}};
      case (ex_alu_out[1:0])
        2'b00:   w_req_be = 4'b1000;
        2'b01:   w_req_be = 4'b0100;
        2'b10:   w_req_be = 4'b0010;
        default: w_req_be = 4'b0001;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response formatting (used in RESP)
  // ---------------------------------------------------------------------------
  logic [7:0]  w_sel_byte;
  logic [31:0] w_load_data;
  logic        w_resp_store;

  assign w_resp_store = (r_op == OP_SW) || (r_op == OP_SB);

  always_comb begin
    // Big-endian lanes: offset 0 is the most significant byte.
    case (r_lane)
      2'b00:   w_sel_byte = r_rdata[31:24];
      2'b01:   w_sel_byte = r_rdata[23:16];
      2'b10:   w_sel_byte = r_rdata[15:8];
      default: w_sel_byte = r_rdata[7:0];
    endcase

    w_load_data = r_rdata;
    if (r_op == OP_LB) begin
      w_load_data = {{24{w_sel_byte[7]}}, w_sel_byte};
    end else if (r_op == OP_LBU) begin
      w_load_data = {24'h00_0000, w_sel_byte};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= 6'd0;
      r_lane     <= 2'd0;
      r_rd       <= 5'd0;
      r_rwe      <= 1'b0;
      r_rdata    <= 32'h0000_0000;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= 32'h0000_0000;
      r_dm_wdata <= 32'h0000_0000;
      r_dm_be    <= 4'b0000;
      r_wb_valid <= 1'b0;
      r_wb_rwe   <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'h0000_0000;
      r_fault    <= 1'b0;
    end else begin
      // wb_valid and fault are single-cycle pulses unless re-asserted below.
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_rwe   <= ex_rwe;
              r_wb_rd    <= ex_rd;
              r_wb_data  <= ex_alu_out;
            end else if (w_misaligned) begin
              // Retire without touching memory or the register file.
              r_wb_valid <= 1'b1;
              r_wb_rwe   <= 1'b0;
              r_wb_rd    <= ex_rd;
              r_wb_data  <= ex_alu_out;
              r_fault    <= 1'b1;
            end else begin
              r_state    <= S_ACCESS;
              r_cnt      <= '0;
              r_op       <= ex_aluop;
              r_lane     <= ex_alu_out[1:0];
              r_rd       <= ex_rd;
              r_rwe      <= ex_rwe;
              r_dm_req   <= 1'b1;
              r_dm_we    <= w_is_store;
              r_dm_addr  <= {ex_alu_out[31:2], 2'b00};
              r_dm_be    <= w_req_be;
              r_dm_wdata <= w_req_wdata;
            end
          end
        end

        S_ACCESS: begin
          // Request fields stay untouched here, so they are stable until ack.
          if (dm.dm_ack) begin
            r_rdata  <= dm.dm_rdata;
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_state  <= S_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th unacknowledged cycle: abandon the access.
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_wb_valid <= 1'b1;
            r_wb_rwe   <= 1'b0;
            r_wb_rd    <= r_rd;
            r_wb_data  <= 32'h0000_0000;
            r_fault    <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          if (w_resp_store) begin
            r_wb_rwe  <= 1'b0;
            r_wb_data <= 32'h0000_0000;
          end else begin
            r_wb_rwe  <= r_rwe;
            r_wb_data <= w_load_data;
          end
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Stall covers the ACCESS cycles and the RESP cycle; it drops as the result
  // enters the writeback register.
  assign stall        = (r_state != S_IDLE);

  assign dm.dm_req    = r_dm_req;
  assign dm.dm_we     = r_dm_we;
  assign dm.dm_addr   = r_dm_addr;
  assign dm.dm_wdata  = r_dm_wdata;
  assign dm.dm_be     = r_dm_be;

  assign wb_valid     = r_wb_valid;
  assign wb_rwe       = r_wb_rwe;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign fault        = r_fault;

  // r0 is hard-wired zero, so it is never forwarded.
  assign mx_bypass    = r_wb_data;
  assign mx_rd        = r_wb_rd;
  assign do_mx_bypass = r_wb_valid && r_wb_rwe && (r_wb_rd != 5'd0);

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// registers on the rising edge. Expected values come from model(), which
// derives request and writeback values from the opcode rules directly.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [5:0] OP_LW  = 6'b010011;
  localparam logic [5:0] OP_SW  = 6'b010100;
  localparam logic [5:0] OP_LB  = 6'b010101;
  localparam logic [5:0] OP_SB  = 6'b010111;
  localparam logic [5:0] OP_LBU = 6'b011000;
  localparam int         TOUT   = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [5:0]  ex_aluop = '0;
  logic [31:0] ex_alu_out = '0;
  logic [31:0] ex_rb = '0;
  logic        ex_rwe = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        stall;
  logic        wb_valid, wb_rwe, do_mx_bypass, fault;
  logic [4:0]  wb_rd, mx_rd;
  logic [31:0] wb_data, mx_bypass;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if dm_bus ();

  mem_stage dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_aluop     (ex_aluop),
    .ex_alu_out   (ex_alu_out),
    .ex_rb        (ex_rb),
    .ex_rwe       (ex_rwe),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .dm           (dm_bus),
    .wb_valid     (wb_valid),
    .wb_rwe       (wb_rwe),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mx_bypass    (mx_bypass),
    .mx_rd        (mx_rd),
    .do_mx_bypass (do_mx_bypass),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void model(
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rb,
    input  logic [31:0] rdata,
    input  logic        rwe,
    output logic        is_mem,
    output logic        mis,
    output logic        store,
    output logic [3:0]  be,
    output logic [31:0] maddr,
    output logic [31:0] wdata,
    output logic [31:0] wbdata,
    output logic        wbrwe
  );
    int unsigned lane;
    logic [31:0] byte_val;
    lane     = addr % 4;
    is_mem   = op inside {OP_LW, OP_SW, OP_LB, OP_SB, OP_LBU};
    store    = (op == OP_SW) || (op == OP_SB);
    mis      = ((op == OP_LW) || (op == OP_SW)) && (lane != 0);
    maddr    = addr - lane;
    be       = (op == OP_SB) ? (4'b1000 >> lane) : 4'b1111;
    wdata    = (op == OP_SW) ? rb : {4{rb[7:0]}};
    byte_val = (rdata >> (8 * (3 - lane))) & 32'hFF;
    if (op == OP_LW)       wbdata = rdata;
    else if (op == OP_LBU) wbdata = byte_val;
    else                   wbdata = (byte_val >= 128) ? (byte_val | 32'hFFFF_FF00) : byte_val;
    wbrwe    = store ? 1'b0 : rwe;
  endfunction

  function automatic logic [5:0] rand_alu_op();
    logic [5:0] op;
    do op = 6'($urandom_range(0, 63));
    while (op inside {OP_LW, OP_SW, OP_LB, OP_SB, OP_LBU});
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // Non-memory instruction, one cycle; caller decides what follows
  // ---------------------------------------------------------------------------
  task automatic do_alu(input string name, input logic [5:0] op, input logic [31:0] alu,
                        input logic [4:0] rd, input logic rwe);
    ex_valid = 1'b1; ex_aluop = op; ex_alu_out = alu; ex_rb = $urandom;
    ex_rwe = rwe; ex_rd = rd;
    @(negedge clock);
    n_checks++;
    if ({wb_valid, wb_rwe, wb_rd, wb_data} !== {1'b1, rwe, rd, alu}) begin
      n_errors++;
      $display("FAIL %s wb: got v=%b rwe=%b rd=%0d data=%h, want v=1 rwe=%b rd=%0d data=%h",
               name, wb_valid, wb_rwe, wb_rd, wb_data, rwe, rd, alu);
    end
    n_checks++;
    if ({do_mx_bypass, mx_rd, mx_bypass} !== {rwe && (rd != 5'd0), rd, alu}) begin
      n_errors++;
      $display("FAIL %s bypass: got do=%b rd=%0d val=%h, want do=%b rd=%0d val=%h",
               name, do_mx_bypass, mx_rd, mx_bypass, rwe && (rd != 5'd0), rd, alu);
    end
    n_checks++;
    if ({stall, fault, dm_bus.dm_req} !== 3'b000) begin
      n_errors++;
      $display("FAIL %s ctrl: got stall=%b fault=%b dm_req=%b, want 0 0 0",
               name, stall, fault, dm_bus.dm_req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory instruction with ack after `delay` unacknowledged ACCESS cycles.
  // Starts and ends on a falling edge with the DUT idle.
  // ---------------------------------------------------------------------------
  task automatic do_mem(input string name, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] rb, input logic rwe, input logic [4:0] rd,
                        input logic [31:0] rdata, input int delay);
    logic is_mem, mis, store, wbrwe;
    logic [3:0] be;
    logic [31:0] maddr, wdata, wbdata, exp_data;
    model(op, addr, rb, rdata, rwe, is_mem, mis, store, be, maddr, wdata, wbdata, wbrwe);

    ex_valid = 1'b1; ex_aluop = op; ex_alu_out = addr; ex_rb = rb; ex_rwe = rwe; ex_rd = rd;
    dm_bus.dm_ack = 1'b0;
    @(negedge clock);

    if (mis) begin
      ex_valid = 1'b0;
      n_checks++;
      if ({dm_bus.dm_req, wb_valid, wb_rwe, fault, stall} !== 5'b01010) begin
        n_errors++;
        $display("FAIL %s misaligned: got req=%b wbv=%b rwe=%b fault=%b stall=%b, want 0 1 0 1 0",
                 name, dm_bus.dm_req, wb_valid, wb_rwe, fault, stall);
      end
      return;
    end

    for (int j = 0; j <= delay; j++) begin
      // Upstream holds new work; it must be ignored while stalled.
      ex_valid = 1'b1; ex_aluop = 6'($urandom); ex_alu_out = $urandom; ex_rd = 5'($urandom);
      n_checks++;
      if ({stall, dm_bus.dm_req, wb_valid, fault} !== 4'b1100) begin
        n_errors++;
        $display("FAIL %s access[%0d] ctrl: got stall=%b req=%b wbv=%b fault=%b, want 1 1 0 0",
                 name, j, stall, dm_bus.dm_req, wb_valid, fault);
      end
      n_checks++;
      if ({dm_bus.dm_we, dm_bus.dm_be, dm_bus.dm_addr} !== {store, be, maddr}) begin
        n_errors++;
        $display("FAIL %s access[%0d] req: got we=%b be=%b addr=%h, want we=%b be=%b addr=%h",
                 name, j, dm_bus.dm_we, dm_bus.dm_be, dm_bus.dm_addr, store, be, maddr);
      end
      if (store) begin
        n_checks++;
        if (dm_bus.dm_wdata !== wdata) begin
          n_errors++;
          $display("FAIL %s access[%0d] wdata: got %h, want %h", name, j, dm_bus.dm_wdata, wdata);
        end
      end
      dm_bus.dm_ack   = (j == delay);
      dm_bus.dm_rdata = (j == delay) ? rdata : $urandom;
      @(negedge clock);
    end

    // RESP cycle
    dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = $urandom;
    ex_valid = 1'b0;
    n_checks++;
    if ({stall, dm_bus.dm_req, wb_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL %s resp: got stall=%b req=%b wbv=%b, want 1 0 0",
               name, stall, dm_bus.dm_req, wb_valid);
    end
    @(negedge clock);

    // Result in the writeback register
    n_checks++;
    if ({stall, dm_bus.dm_req, wb_valid, fault, wb_rwe, wb_rd} !== {4'b0010, wbrwe, rd}) begin
      n_errors++;
      $display("FAIL %s wb: got stall=%b req=%b wbv=%b fault=%b rwe=%b rd=%0d, want 0 0 1 0 %b %0d",
               name, stall, dm_bus.dm_req, wb_valid, fault, wb_rwe, wb_rd, wbrwe, rd);
    end
    if (!store) begin
      exp_data = wbdata;
      n_checks++;
      if ({wb_data, mx_bypass, mx_rd, do_mx_bypass} !== {exp_data, exp_data, rd, rwe && (rd != 5'd0)}) begin
        n_errors++;
        $display("FAIL %s load data: got wb=%h mx=%h mxrd=%0d do=%b, want %h %h %0d %b",
                 name, wb_data, mx_bypass, mx_rd, do_mx_bypass, exp_data, exp_data, rd,
                 rwe && (rd != 5'd0));
      end
    end else begin
      n_checks++;
      if (do_mx_bypass !== 1'b0) begin
        n_errors++;
        $display("FAIL %s store bypass: got do=%b, want 0", name, do_mx_bypass);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_aluop = 6'($urandom); ex_alu_out = $urandom; ex_rb = $urandom;
      ex_rwe = 1'b1; ex_rd = 5'($urandom);
      dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = $urandom;
      @(negedge clock);
    end
    n_checks++;
    if ((|{stall, dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_addr, dm_bus.dm_wdata, dm_bus.dm_be,
           wb_valid, wb_rwe, wb_rd, wb_data, mx_bypass, mx_rd, do_mx_bypass, fault}) !== 1'b0) begin
      n_errors++;
      $display("FAIL reset outputs: got stall=%b req=%b be=%b addr=%h wbv=%b wbdata=%h fault=%b, want all 0",
               stall, dm_bus.dm_req, dm_bus.dm_be, dm_bus.dm_addr, wb_valid, wb_data, fault);
    end
    reset_n = 1'b1; ex_valid = 1'b0; dm_bus.dm_ack = 1'b0;
  endtask

  task automatic test_alu();
    do_alu("add", 6'b000001, 32'h0000_0005, 5'd3, 1'b1);
    for (int i = 0; i < 6; i++)
      do_alu("alu_rand", rand_alu_op(), $urandom, 5'($urandom), 1'($urandom));
    do_alu("alu_r0", rand_alu_op(), $urandom, 5'd0, 1'b1);
  endtask

  task automatic test_idle();
    ex_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({wb_valid, do_mx_bypass, stall} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle: got wbv=%b do=%b stall=%b, want 0 0 0", wb_valid, do_mx_bypass, stall);
    end
  endtask

  task automatic test_load_byte();
    do_mem("lb",  OP_LB,  32'h0000_1001, $urandom, 1'b1, 5'd7, 32'h1280_3456, 1);
    do_mem("lbu", OP_LBU, 32'h0000_1001, $urandom, 1'b1, 5'd8, 32'h1280_3456, 1);
  endtask

  task automatic test_store_byte();
    do_mem("sb", OP_SB, 32'h0000_2003, 32'h0000_00AB, 1'b1, 5'd9, $urandom, 0);
    do_mem("sw", OP_SW, 32'h0000_2004, 32'hDEAD_BEEF, 1'b1, 5'd9, $urandom, 2);
  endtask

  task automatic test_misaligned();
    do_mem("lw_mis", OP_LW, 32'h0000_0002, $urandom, 1'b1, 5'd4, $urandom, 0);
    test_idle();  // fault is a single-cycle pulse
    n_checks++;
    if (fault !== 1'b0) begin
      n_errors++;
      $display("FAIL fault_pulse: got fault=%b, want 0", fault);
    end
    do_mem("sw_mis", OP_SW, 32'h0000_0003, $urandom, 1'b1, 5'd4, $urandom, 0);
  endtask

  task automatic test_back_to_back();
    // Minimum latency load, then an ALU op accepted the very next cycle.
    do_mem("lw_fast", OP_LW, 32'h0000_0100, $urandom, 1'b1, 5'd5, 32'hCAFE_F00D, 0);
    do_alu("after_load", rand_alu_op(), $urandom, 5'd6, 1'b1);
    do_mem("lb_b2b", OP_LB, 32'h0000_0103, $urandom, 1'b1, 5'd10, 32'h0102_037F, 0);
    test_idle();
  endtask

  task automatic test_random_mem();
    logic [5:0] ops [5] = '{OP_LW, OP_SW, OP_LB, OP_SB, OP_LBU};
    for (int i = 0; i < 25; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_mem("mem_rand", ops[$urandom_range(0, 4)], a, $urandom, 1'($urandom),
             5'($urandom), $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1)
        do_alu("mix_alu", rand_alu_op(), $urandom, 5'($urandom), 1'($urandom));
    end
    test_idle();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int guard = 0;
    ex_valid = 1'b1; ex_aluop = OP_LW; ex_alu_out = 32'h0000_0040; ex_rwe = 1'b1; ex_rd = 5'd12;
    dm_bus.dm_ack = 1'b0;
    @(negedge clock);
    ex_valid = 1'b0;
    while (dm_bus.dm_req === 1'b1 && guard < 4 * TOUT) begin
      req_cycles++; guard++;
      @(negedge clock);
    end
    n_checks++;
    if (req_cycles != TOUT) begin
      n_errors++;
      $display("FAIL timeout_len: got dm_req high %0d cycles, want %0d", req_cycles, TOUT);
    end
    n_checks++;
    if ({fault, wb_valid, wb_rwe, stall, do_mx_bypass} !== 5'b11000) begin
      n_errors++;
      $display("FAIL timeout_retire: got fault=%b wbv=%b rwe=%b stall=%b do=%b, want 1 1 0 0 0",
               fault, wb_valid, wb_rwe, stall, do_mx_bypass);
    end
    @(negedge clock);
    n_checks++;
    if ({fault, wb_valid, stall, dm_bus.dm_req} !== 4'b0000) begin
      n_errors++;
      $display("FAIL timeout_after: got fault=%b wbv=%b stall=%b req=%b, want 0 0 0 0",
               fault, wb_valid, stall, dm_bus.dm_req);
    end
    // The stage must be back in IDLE and accept work immediately.
    do_alu("after_timeout", rand_alu_op(), 32'h1234_5678, 5'd2, 1'b1);
  endtask

  task automatic test_reset_mid_access();
    ex_valid = 1'b1; ex_aluop = OP_LW; ex_alu_out = 32'h0000_0200; ex_rwe = 1'b1; ex_rd = 5'd13;
    dm_bus.dm_ack = 1'b0;
    @(negedge clock);
    ex_valid = 1'b0;
    n_checks++;
    if (dm_bus.dm_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_access_req: got dm_req=%b, want 1", dm_bus.dm_req);
    end
    reset_n = 1'b0;
    @(negedge clock);
    n_checks++;
    if ((|{stall, dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_addr, dm_bus.dm_wdata, dm_bus.dm_be,
           wb_valid, wb_rwe, wb_rd, wb_data, mx_bypass, mx_rd, do_mx_bypass, fault}) !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_access_zero: got stall=%b req=%b addr=%h be=%b wbv=%b, want all 0",
               stall, dm_bus.dm_req, dm_bus.dm_addr, dm_bus.dm_be, wb_valid);
    end
    reset_n = 1'b1;
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({dm_bus.dm_req, wb_valid, stall, fault} !== 4'b0000) begin
        n_errors++;
        $display("FAIL late_ack[%0d]: got req=%b wbv=%b stall=%b fault=%b, want 0 0 0 0",
                 i, dm_bus.dm_req, wb_valid, stall, fault);
      end
    end
    dm_bus.dm_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    dm_bus.dm_ack   = 1'b0;
    dm_bus.dm_rdata = 32'h0;
    @(negedge clock);
    test_reset();
    test_alu();
    test_idle();
    test_load_byte();
    test_store_byte();
    test_misaligned();
    test_back_to_back();
    test_random_mem();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
